// File: rtl/add_pipelined.sv
// Two-operand adder with optional saturation, carry/overflow flags and a
// clock-enabled register pipeline of LATENCY stages (0 = combinational).
module add_pipelined #(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 1,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clken,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = WIDTH + 2;

  localparam logic [WIDTH-1:0] MAX_U = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_S = {1'b0, {MSB{1'b1}}};
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {MSB{1'b0}}};

  // Two's-complement overflow: like-signed operands producing a sum of the other sign.
  function automatic logic signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Clamp the raw sum; flags are computed separately and never see this value.
  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] raw,
    input logic             carry,
    input logic             sovf,
    input logic             a_msb
  );
    logic [WIDTH-1:0] r;
    r = raw;
    if (SATURATE == 0) begin
      r = raw;
    end else if (SIGNED != 0) begin
      if (sovf) begin
        r = a_msb ? MIN_S : MAX_S;
      end else begin
        r = raw;
      end
    end else begin
      if (carry) begin
        r = MAX_U;
      end else begin
        r = raw;
      end
    end
    return r;
  endfunction

  logic [WIDTH:0]   sum_s;
  logic             cout_s;
  logic             sovf_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_s;
  logic [SW-1:0]    head_s;

  assign sum_s = {1'b0, dataa} + {1'b0, datab};

  // Flag and result computation from the raw WIDTH+1 bit sum.
  always_comb begin
    cout_s = sum_s[WIDTH];
    sovf_s = signed_ovf(dataa[MSB], datab[MSB], sum_s[MSB]);
    if (SIGNED != 0) begin
      ovf_s = sovf_s;
    end else begin
      ovf_s = cout_s;
    end
    res_s  = clamp(sum_s[WIDTH-1:0], cout_s, sovf_s, dataa[MSB]);
    head_s = {ovf_s, cout_s, res_s};
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign {overflow, cout, result} = head_s;
    end else begin : g_pipe
      logic [SW-1:0] stage_r [LATENCY];

      // Shift register of {overflow,cout,result}; aclr wipes every stage at once.
      always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
          for (int i = 0; i < LATENCY; i++) begin
            stage_r[i] <= {SW{1'b0}};
          end
        end else if (clken) begin
          for (int i = LATENCY - 1; i > 0; i--) begin
            stage_r[i] <= stage_r[i-1];
          end
          stage_r[0] <= head_s;
        end
      end

      assign {overflow, cout, result} = stage_r[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_add_pipelined.sv
// Bench for add_pipelined: several parameterisations share one stimulus stream and
// are compared against an integer-arithmetic model over a history of enabled samples.
module tb_add_pipelined;

  localparam int N = 8;
  localparam int LAT [N] = '{1, 1, 1, 1, 3, 0, 0, 2};
  localparam int SGN [N] = '{0, 0, 1, 1, 0, 0, 1, 1};
  localparam int SAT [N] = '{0, 1, 0, 1, 0, 0, 1, 1};

  logic       clock = 1'b0;
  logic       aclr;
  logic       clken;
  logic [7:0] dataa;
  logic [7:0] datab;
  logic [7:0] res_w  [N];
  logic       cout_w [N];
  logic       ovf_w  [N];

  int checks = 0;
  int errors = 0;
  logic [15:0] hist [$];

  always #5 clock = ~clock;

  add_pipelined #(.WIDTH(8), .LATENCY(LAT[0]), .SIGNED(SGN[0]), .SATURATE(SAT[0])) u0 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[0]), .cout(cout_w[0]), .overflow(ovf_w[0]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[1]), .SIGNED(SGN[1]), .SATURATE(SAT[1])) u1 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[1]), .cout(cout_w[1]), .overflow(ovf_w[1]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[2]), .SIGNED(SGN[2]), .SATURATE(SAT[2])) u2 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[2]), .cout(cout_w[2]), .overflow(ovf_w[2]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[3]), .SIGNED(SGN[3]), .SATURATE(SAT[3])) u3 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[3]), .cout(cout_w[3]), .overflow(ovf_w[3]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[4]), .SIGNED(SGN[4]), .SATURATE(SAT[4])) u4 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[4]), .cout(cout_w[4]), .overflow(ovf_w[4]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[5]), .SIGNED(SGN[5]), .SATURATE(SAT[5])) u5 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[5]), .cout(cout_w[5]), .overflow(ovf_w[5]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[6]), .SIGNED(SGN[6]), .SATURATE(SAT[6])) u6 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[6]), .cout(cout_w[6]), .overflow(ovf_w[6]));
  add_pipelined #(.WIDTH(8), .LATENCY(LAT[7]), .SIGNED(SGN[7]), .SATURATE(SAT[7])) u7 (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(dataa), .datab(datab),
    .result(res_w[7]), .cout(cout_w[7]), .overflow(ovf_w[7]));

  // Reference: plain integer addition, range checks and clamping.
  function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                           input int sgn, input int sat);
    int us;
    int ss;
    logic c;
    logic o;
    logic [7:0] r;
    us = int'(a) + int'(b);
    ss = int'($signed(a)) + int'($signed(b));
    c  = (us > 255);
    o  = (sgn != 0) ? ((ss > 127) || (ss < -128)) : c;
    r  = us[7:0];
    if (sat != 0) begin
      if (sgn != 0) begin
        if (ss > 127) r = 8'h7F;
        else if (ss < -128) r = 8'h80;
      end else if (c) begin
        r = 8'hFF;
      end
    end
    return {o, c, r};
  endfunction

  function automatic logic [9:0] expected(input int k);
    int n;
    logic [15:0] p;
    if (LAT[k] == 0) return ref_model(dataa, datab, SGN[k], SAT[k]);
    n = hist.size();
    if (n < LAT[k]) return 10'h000;
    p = hist[n - LAT[k]];
    return ref_model(p[15:8], p[7:0], SGN[k], SAT[k]);
  endfunction

  task automatic check_all(input string tag);
    logic [9:0] obs;
    logic [9:0] exp;
    for (int k = 0; k < N; k++) begin
      exp = expected(k);
      obs = {ovf_w[k], cout_w[k], res_w[k]};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s inst%0d observed {ovf,cout,res}=%h expected %h", tag, k, obs, exp);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    if (!aclr && clken) hist.push_back({dataa, datab});
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    dataa = a;
    datab = b;
  endtask

  task automatic pulse_reset(input string tag);
    aclr = 1'b1;
    hist.delete();
    #1;
    check_all(tag);
    aclr = 1'b0;
  endtask

  function automatic logic [7:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    aclr  = 1'b1;
    clken = 1'b0;
    drive(8'd0, 8'd0);
    #2;
    check_all("reset");
    clken = 1'b1;
    tick("reset_held");

    aclr = 1'b0;
    drive(8'd5, 8'd10);
    tick("first");
    drive(8'd11, 8'd10);
    tick("stream1");
    drive(8'd3, 8'd10);
    tick("stream2");
    drive(8'd200, 8'd100);
    tick("wrap");
    drive(8'd100, 8'd100);
    tick("sovf_pos");
    drive(8'd156, 8'd156);
    tick("sovf_neg");
    drive(8'd255, 8'd1);
    tick("carry_edge");

    pulse_reset("reset_mid");
    drive(8'd1, 8'd1);
    tick("fill1");
    drive(8'd2, 8'd2);
    tick("fill2");
    drive(8'd3, 8'd3);
    tick("fill3");
    clken = 1'b0;
    drive(8'd9, 8'd9);
    tick("stall1");
    drive(8'd40, 8'd41);
    tick("stall2");
    clken = 1'b1;
    tick("drain1");
    tick("drain2");
    tick("drain3");
    pulse_reset("reset_between");
    tick("after_reset");

    drive(8'd7, 8'd9);
    #1;
    check_all("comb");

    for (int i = 0; i < 400; i++) begin
      drive(rnd_operand(), rnd_operand());
      clken = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) pulse_reset("rand_reset");
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
